// File: rtl/asap_pkg.sv
// Shared types and clock-derived defaults for the button front end.
package asap_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ        = 25_000_000;
  localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with down-time counter,
// registered level and single-cycle press/release pulses.
//
// state        | meaning
// IDLE         | released and accepted; waiting for s=1
// PRESS_WAIT   | s=1 seen, counting qualification cycles
// PRESSED      | press accepted, level=1
// RELEASE_WAIT | s=0 seen while pressed, counting; level still 1
module debounce_channel
  import asap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_sync    <= '0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
      r_press   <= (r_state == PRESS_WAIT) && (w_state_nxt == PRESSED);
      r_release <= (r_state == RELEASE_WAIT) && (w_state_nxt == IDLE);
    end
  end

  // The state leaves a WAIT state at CNT_LAST, so the counter cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s)                   w_state_nxt = IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = PRESSED;
        else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s)                    w_state_nxt = PRESSED;
        else if (r_cnt == CNT_LAST) w_state_nxt = IDLE;
        else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: pad polarity correction and one debounce channel per button,
// packed onto the level/press/release buses.
module button_conditioner
  import asap_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit          ACTIVE_LOW      = 1'b1,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o
);

  logic [NUM_BTN-1:0] w_btn;

  // Inverted before synchronizing so every channel works in "1 = pressed".
  assign w_btn = ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst       (rst),
      .i_btn     (w_btn[g]),
      .o_level   (btn_level_o[g]),
      .o_press   (btn_press_o[g]),
      .o_release (btn_release_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: an active-high and an active-low build,
// checked each cycle against a queue of expected press/release events.
module tb_button_conditioner;

  localparam int D   = 8;
  localparam int LAT = D + 2;

  typedef struct {
    int cyc;
    int inst;
    int ch;
    bit rel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pad0 = 3'b000;
  logic [2:0] pad1 = 3'b111;
  logic [2:0] level_w   [2];
  logic [2:0] press_w   [2];
  logic [2:0] release_w [2];

  int   cyc   = 0;
  logic rst_q = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [2:0] exp_level [2];

  button_conditioner #(
    .NUM_BTN(3), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)
  ) dut0 (
    .clk_i(clk), .rst(rst), .btn_raw_i(pad0),
    .btn_level_o(level_w[0]), .btn_press_o(press_w[0]), .btn_release_o(release_w[0])
  );

  button_conditioner #(
    .NUM_BTN(3), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk_i(clk), .rst(rst), .btn_raw_i(pad1),
    .btn_level_o(level_w[1]), .btn_press_o(press_w[1]), .btn_release_o(release_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic expect_ev(input int c, input int inst, input int ch, input bit rel);
    sb.push_back('{cyc: c, inst: inst, ch: ch, rel: rel});
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Per-cycle monitor: every pulse bit and level bit against the scoreboard.
  always @(negedge clk) begin
    if (rst_q) begin
      exp_level[0] = 3'b000;
      exp_level[1] = 3'b000;
    end
    for (int inst = 0; inst < 2; inst++) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int k = 0; k < 2; k++) begin
          logic e;
          logic o;
          e = 1'b0;
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc && sb[i].inst == inst && sb[i].ch == ch &&
                sb[i].rel == bit'(k)) begin
              e = 1'b1;
              sb.delete(i);
            end
          end
          o = (k == 1) ? release_w[inst][ch] : press_w[inst][ch];
          check($sformatf("%s inst%0d ch%0d", (k == 1) ? "release" : "press", inst, ch), o, e);
          if (e) exp_level[inst][ch] = (k == 0);
        end
        check($sformatf("level inst%0d ch%0d", inst, ch), level_w[inst][ch],
              exp_level[inst][ch]);
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    exp_level[0] = 3'b000;
    exp_level[1] = 3'b000;

    // Reset state
    ticks(3);
    check("reset level0", level_w[0] == 3'b000, 1'b1);
    check("reset level1", level_w[1] == 3'b000, 1'b1);
    rst = 1'b0;
    ticks(2);

    // Clean press/release on channel 0
    k = cyc + 1;
    pad0[0] = 1'b1;
    expect_ev(k + LAT, 0, 0, 1'b0);
    ticks(40);
    k = cyc + 1;
    pad0[0] = 1'b0;
    expect_ev(k + LAT, 0, 0, 1'b1);
    ticks(15);

    // Bounce 1,0,1,0 every 3 cycles, then settle high
    for (int b = 0; b < 4; b++) begin
      pad0[0] = (b % 2 == 0);
      ticks(3);
    end
    k = cyc + 1;
    pad0[0] = 1'b1;
    expect_ev(k + LAT, 0, 0, 1'b0);
    ticks(15);

    // Glitch to 0 for 5 cycles while pressed: no pulses, level held
    pad0[0] = 1'b0;
    ticks(5);
    pad0[0] = 1'b1;
    ticks(15);
    check("glitch level held", level_w[0][0], 1'b1);
    k = cyc + 1;
    pad0[0] = 1'b0;
    expect_ev(k + LAT, 0, 0, 1'b1);
    ticks(15);

    // Simultaneous press on channels 0 and 2
    k = cyc + 1;
    pad0 = 3'b101;
    expect_ev(k + LAT, 0, 0, 1'b0);
    expect_ev(k + LAT, 0, 2, 1'b0);
    ticks(15);
    k = cyc + 1;
    pad0 = 3'b000;
    expect_ev(k + LAT, 0, 0, 1'b1);
    expect_ev(k + LAT, 0, 2, 1'b1);
    ticks(15);

    // Reset while channel 1 is pressed and still held
    k = cyc + 1;
    pad0[1] = 1'b1;
    expect_ev(k + LAT, 0, 1, 1'b0);
    ticks(13);
    rst = 1'b1;
    ticks(1);
    check("reset edge level ch1", level_w[0][1], 1'b0);
    check("reset edge release ch1", release_w[0][1], 1'b0);
    ticks(1);
    rst = 1'b0;
    k = cyc + 1;
    expect_ev(k + LAT, 0, 1, 1'b0);
    ticks(15);
    check("requalified level ch1", level_w[0][1], 1'b1);
    k = cyc + 1;
    pad0[1] = 1'b0;
    expect_ev(k + LAT, 0, 1, 1'b1);
    ticks(15);

    // Active-low build: pad 0 low for 20 cycles
    k = cyc + 1;
    pad1[0] = 1'b0;
    expect_ev(k + LAT, 1, 0, 1'b0);
    ticks(20);
    k = cyc + 1;
    pad1[0] = 1'b1;
    expect_ev(k + LAT, 1, 0, 1'b1);
    ticks(15);

    check("scoreboard drained", sb.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
